// File: rtl/max7219_frame_sequencer.sv
// max7219_frame_sequencer: streams MAX7219 init, intensity and row commands
// over a valid/ready command port. The frame buffer is held in registers.
// When MAX7219_SEQ_DOUBLE_BUF_EN is defined there are two buffers: row writes
// go to the back buffer, and the buffers swap at frame start so each frame
// sends a snapshot. When it is undefined, row writes go to the live buffer.
module max7219_frame_sequencer #(
  parameter logic [2:0] INIT_SCAN_LIMIT = 3'd7,
  parameter logic       AUTO_REFRESH    = 1'b0
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_row_we,
  input  logic [2:0] i_row_addr,
  input  logic [7:0] i_row_data,
  input  logic       i_frame_req,
  input  logic [3:0] i_intensity,
  output logic       o_cmd_valid,
  output logic [3:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  input  logic       i_cmd_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_INTEN,
    S_ROWS,
    S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_step, w_step_next;
  logic        r_cmd_valid, w_cmd_valid_next;
  logic [3:0]  r_cmd_addr, w_cmd_addr_next;
  logic [7:0]  r_cmd_data, w_cmd_data_next;
  logic        r_frame_done, w_frame_done_next;
  logic        r_pending, w_pending_next;
  logic [3:0]  r_last_int, w_last_int_next;

  logic        w_fire;
  logic        w_start;
  logic [2:0]  w_init_step;
  logic [11:0] w_init_cmd;
  logic [2:0]  w_rd_row;
  logic [7:0]  w_front_row;
  logic [7:0]  w_start_row0;
  logic [7:0]  w_row_wr;

  // One-hot row write enables.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row_wr
      assign w_row_wr[gi] = i_row_we && (i_row_addr == 3'(gi));
    end
  endgenerate

`ifdef MAX7219_SEQ_DOUBLE_BUF_EN
  logic [7:0] r_buf [2][8];
  logic       r_front;
  logic       w_wr_sel;

  // A write that lands in the same cycle as a swap belongs to the new back buffer.
  assign w_wr_sel = w_start ? r_front : ~r_front;

  // Back-buffer writes and the front/back swap at frame start.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_buf[0][i] <= 8'h00;
        r_buf[1][i] <= 8'h00;
      end
    end else begin
      if (w_start) r_front <= ~r_front;
      for (int i = 0; i < 8; i++) begin
        if (w_row_wr[i]) r_buf[w_wr_sel][i] <= i_row_data;
      end
    end
  end

  // Row 0 is loaded at the swap edge, so it comes from the buffer about to become front.
  assign w_front_row  = r_buf[r_front][w_rd_row];
  assign w_start_row0 = r_buf[~r_front][0];
`else
  logic [7:0] r_buf [8];

  // Single live buffer; rows already loaded into the command register are unaffected.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_row_wr[i]) r_buf[i] <= i_row_data;
      end
    end
  end

  assign w_front_row  = r_buf[w_rd_row];
  assign w_start_row0 = r_buf[0];
`endif

  assign w_fire      = r_cmd_valid & i_cmd_ready;
  // In ROWS, the next row follows the one being accepted. Otherwise row 0 comes next.
  assign w_rd_row    = (r_state == S_ROWS) ? r_step + 3'd1 : 3'd0;
  // The first INIT command is presented before any command is valid.
  assign w_init_step = r_cmd_valid ? r_step + 3'd1 : r_step;

  // Power-up command table indexed by INIT step.
  always_comb begin
    w_init_cmd = {4'hF, 8'h00};
    case (w_init_step)
      3'd0:    w_init_cmd = {4'hC, 8'h01};
      3'd1:    w_init_cmd = {4'h9, 8'h00};
      3'd2:    w_init_cmd = {4'hB, 5'd0, INIT_SCAN_LIMIT};
      3'd3:    w_init_cmd = {4'hA, 4'h0, i_intensity};
      default: w_init_cmd = {4'hF, 8'h00};
    endcase
  end

  // Next-state logic. The command register is loaded only when a new command is
  // presented, so it stays stable while the serializer stalls.
  always_comb begin
    w_state_next      = r_state;
    w_step_next       = r_step;
    w_cmd_valid_next  = r_cmd_valid;
    w_cmd_addr_next   = r_cmd_addr;
    w_cmd_data_next   = r_cmd_data;
    w_frame_done_next = 1'b0;
    w_pending_next    = r_pending;
    w_last_int_next   = r_last_int;
    w_start           = 1'b0;

    case (r_state)
      S_INIT: begin
        if (i_frame_req) w_pending_next = 1'b1;
        if (!r_cmd_valid || w_fire) begin
          if (r_cmd_valid && (r_step == 3'd4)) begin
            w_state_next     = S_IDLE;
            w_step_next      = 3'd0;
            w_cmd_valid_next = 1'b0;
          end else begin
            w_step_next      = w_init_step;
            w_cmd_valid_next = 1'b1;
            w_cmd_addr_next  = w_init_cmd[11:8];
            w_cmd_data_next  = w_init_cmd[7:0];
            if (w_init_step == 3'd3) w_last_int_next = i_intensity;
          end
        end
      end
      S_IDLE: begin
        w_start = i_frame_req | r_pending;
      end
      S_INTEN: begin
        if (i_frame_req) w_pending_next = 1'b1;
        if (w_fire) begin
          w_state_next    = S_ROWS;
          w_step_next     = 3'd0;
          w_cmd_addr_next = 4'h1;
          w_cmd_data_next = w_front_row;
        end
      end
      S_ROWS: begin
        if (i_frame_req) w_pending_next = 1'b1;
        if (w_fire) begin
          // Leave ROWS on acceptance of row 7 instead of letting the counter wrap.
          if (r_step == 3'd7) begin
            w_state_next      = S_DONE;
            w_step_next       = 3'd0;
            w_cmd_valid_next  = 1'b0;
            w_frame_done_next = 1'b1;
          end else begin
            w_step_next     = r_step + 3'd1;
            w_cmd_addr_next = {1'b0, r_step} + 4'd2;
            w_cmd_data_next = w_front_row;
          end
        end
      end
      S_DONE: begin
        w_start = AUTO_REFRESH | r_pending;
        if (!w_start) begin
          // A request arriving during DONE is kept and served from IDLE.
          w_state_next   = S_IDLE;
          w_pending_next = i_frame_req;
        end
      end
      default: begin
        w_state_next = S_INIT;
        w_step_next  = 3'd0;
      end
    endcase

    if (w_start) begin
      // Starting a frame clears the pending request. A new request in DONE stays pending.
      w_pending_next   = (r_state == S_DONE) ? i_frame_req : 1'b0;
      w_cmd_valid_next = 1'b1;
      w_step_next      = 3'd0;
      if (i_intensity != r_last_int) begin
        w_state_next    = S_INTEN;
        w_cmd_addr_next = 4'hA;
        w_cmd_data_next = {4'h0, i_intensity};
        w_last_int_next = i_intensity;
      end else begin
        w_state_next    = S_ROWS;
        w_cmd_addr_next = 4'h1;
        w_cmd_data_next = w_start_row0;
      end
    end
  end

  // State and output registers. Reset stops any transfer in progress and restarts INIT.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_INIT;
      r_step       <= 3'd0;
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= 4'h0;
      r_cmd_data   <= 8'h00;
      r_frame_done <= 1'b0;
      r_pending    <= 1'b0;
      r_last_int   <= 4'h0;
    end else begin
      r_state      <= w_state_next;
      r_step       <= w_step_next;
      r_cmd_valid  <= w_cmd_valid_next;
      r_cmd_addr   <= w_cmd_addr_next;
      r_cmd_data   <= w_cmd_data_next;
      r_frame_done <= w_frame_done_next;
      r_pending    <= w_pending_next;
      r_last_int   <= w_last_int_next;
    end
  end

  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_addr   = r_cmd_addr;
  assign o_cmd_data   = r_cmd_data;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

endmodule
